// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI message sequencer.
// State encoding, byte-class decode and status nibble constants.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA1,
        DATA2,
        HOLD
    } seqState_t;

    typedef enum logic [2:0] {
        BC_DATA,
        BC_NOTE,
        BC_OTHER,
        BC_SYS,
        BC_RT
    } byteClass_t;

    localparam logic [3:0] NOTE_OFF_NIB = 4'h8;
    localparam logic [3:0] NOTE_ON_NIB  = 4'h9;
    localparam logic [7:0] SYS_BASE     = 8'hF0;
    localparam logic [7:0] RT_BASE      = 8'hF8;

    function automatic byteClass_t classifyByte(input logic [7:0] b);
        byteClass_t c;
        if (b >= RT_BASE)
            c = BC_RT;
        else if (b >= SYS_BASE)
            c = BC_SYS;
        else if (!b[7])
            c = BC_DATA;
        else if (b[7:4] == NOTE_OFF_NIB || b[7:4] == NOTE_ON_NIB)
            c = BC_NOTE;
        else
            c = BC_OTHER;
        return c;
    endfunction

endpackage

// File: rtl/midi_timeout_timer.sv
// Clear/enable counter that saturates at pLimit and flags expiry while enabled.
module midi_timeout_timer #(
    parameter int unsigned pWidth = 16,
    parameter int unsigned pLimit = 50000
) (
    input  logic gClock,
    input  logic gReset,
    input  logic iClear,
    input  logic iEnable,
    output logic oExpired
);

    localparam logic [pWidth-1:0] cLimit = pWidth'(pLimit);

    logic [pWidth-1:0] count;

    always_ff @(posedge gClock) begin
        if (!gReset || iClear)
            count <= '0;
        else if (iEnable && count != cLimit)
            count <= count + 1'b1;
    end

    assign oExpired = iEnable && (count == cLimit);

endmodule

// File: rtl/midi_msg_sequencer.sv
// Pops bytes from the UART FIFO, assembles Note-On/Off messages with running status,
// filters by channel and hands them downstream. Option: NOTE_ON_ZERO_AS_OFF_EN.
module midi_msg_sequencer
    import midi_pkg::*;
#(
    parameter int unsigned pTimeoutCycles = 50000,
    parameter int unsigned pTimerWidth    = 16
) (
    input  logic        gClock,
    input  logic        gReset,
    input  logic [7:0]  iByte,
    input  logic        iByteValid,
    output logic        oByteRead,
    input  logic [15:0] iChannelMask,
    output logic [7:0]  oStatus,
    output logic [7:0]  oNote,
    output logic [7:0]  oVelocity,
    output logic        oMsgValid,
    input  logic        iMsgReady,
    output logic        oTimeout
);

    seqState_t  state;
    seqState_t  nextState;
    byteClass_t byteClass;

    logic       readPrev;
    logic [7:0] runStatus;
    logic       runNote;
    logic [7:0] noteReg;
    logic [7:0] outStatus;
    logic       timeoutPulse;
    logic       maskHit;
    logic       timerClear;
    logic       timerEnable;
    logic       expired;

    assign byteClass = classifyByte(iByte);
    assign maskHit   = iChannelMask[runStatus[3:0]];

    always_ff @(posedge gClock) begin
        if (!gReset)
            state <= IDLE;
        else
            state <= nextState;
    end

    // A pop always wins over a simultaneous expiry; the timer enable is gated by it too.
    always_comb begin
        nextState = state;
        if (state == HOLD) begin
            if (iMsgReady)
                nextState = IDLE;
        end else if (oByteRead) begin
            unique case (byteClass)
                BC_RT:            nextState = state;
                BC_SYS, BC_OTHER: nextState = IDLE;
                BC_NOTE:          nextState = DATA1;
                BC_DATA: begin
                    unique case (state)
                        IDLE:    if (runNote) nextState = DATA2;
                        DATA1:   nextState = DATA2;
                        DATA2:   nextState = maskHit ? HOLD : IDLE;
                        default: nextState = state;
                    endcase
                end
                default:          nextState = state;
            endcase
        end else if (expired) begin
            nextState = IDLE;
        end
    end

    always_comb begin
        oByteRead = gReset && iByteValid && (state != HOLD) && !readPrev;
        oMsgValid = (state == HOLD);
    end

    always_comb begin
        outStatus = runStatus;
`ifdef NOTE_ON_ZERO_AS_OFF_EN
        if (runStatus[7:4] == NOTE_ON_NIB && iByte == 8'h00)
            outStatus = {NOTE_OFF_NIB, runStatus[3:0]};
`endif
    end

    assign timerClear  = (state == IDLE) || (state == HOLD) || (oByteRead && byteClass != BC_RT);
    assign timerEnable = ((state == DATA1) || (state == DATA2)) && !oByteRead;

    midi_timeout_timer #(
        .pWidth (pTimerWidth),
        .pLimit (pTimeoutCycles)
    ) timeoutTimer (
        .gClock   (gClock),
        .gReset   (gReset),
        .iClear   (timerClear),
        .iEnable  (timerEnable),
        .oExpired (expired)
    );

    always_ff @(posedge gClock) begin
        if (!gReset) begin
            readPrev     <= 1'b0;
            timeoutPulse <= 1'b0;
            runStatus    <= '0;
            runNote      <= 1'b0;
            noteReg      <= '0;
            oStatus      <= '0;
            oNote        <= '0;
            oVelocity    <= '0;
        end else begin
            readPrev     <= oByteRead;
            timeoutPulse <= expired;
            if (oByteRead) begin
                unique case (byteClass)
                    BC_SYS: runNote <= 1'b0;
                    BC_NOTE: begin
                        runStatus <= iByte;
                        runNote   <= 1'b1;
                    end
                    BC_OTHER: begin
                        runStatus <= iByte;
                        runNote   <= 1'b0;
                    end
                    BC_DATA: begin
                        if ((state == IDLE && runNote) || state == DATA1)
                            noteReg <= iByte;
                        if (state == DATA2 && maskHit) begin
                            oStatus   <= outStatus;
                            oNote     <= noteReg;
                            oVelocity <= iByte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign oTimeout = timeoutPulse;

endmodule

// File: tb/tb_midi_msg_sequencer.sv
// Randomised bench for midi_msg_sequencer against a byte-stream parsing model.
module tb_midi_msg_sequencer;

    typedef struct {
        logic [7:0] st;
        logic [7:0] nt;
        logic [7:0] vl;
    } msg_t;

    logic        gClock = 1'b0;
    logic        gReset = 1'b0;
    logic [7:0]  iByte = 8'h00;
    logic        iByteValid = 1'b0;
    logic        oByteRead;
    logic [15:0] iChannelMask = 16'hFFFF;
    logic [7:0]  oStatus;
    logic [7:0]  oNote;
    logic [7:0]  oVelocity;
    logic        oMsgValid;
    logic        iMsgReady = 1'b0;
    logic        oTimeout;

    midi_msg_sequencer #(
        .pTimeoutCycles (50000),
        .pTimerWidth    (16)
    ) dut (
        .gClock       (gClock),
        .gReset       (gReset),
        .iByte        (iByte),
        .iByteValid   (iByteValid),
        .oByteRead    (oByteRead),
        .iChannelMask (iChannelMask),
        .oStatus      (oStatus),
        .oNote        (oNote),
        .oVelocity    (oVelocity),
        .oMsgValid    (oMsgValid),
        .iMsgReady    (iMsgReady),
        .oTimeout     (oTimeout)
    );

    always #5 gClock = ~gClock;

    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: parses the byte stream exactly as written into the FIFO.
    logic [7:0] fifo[$];
    msg_t       expQ[$];
    logic [7:0] mRs = 8'h00;
    bit         mRsNote = 0;
    logic [7:0] mPend[$];

    function automatic void modelByte(input logic [7:0] b);
        msg_t m;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin
            mRsNote = 0;
            mPend.delete();
            return;
        end
        if (b[7]) begin
            mRs = b;
            mRsNote = (b[7:4] == 4'h8) || (b[7:4] == 4'h9);
            mPend.delete();
            return;
        end
        if (!mRsNote) return;
        mPend.push_back(b);
        if (mPend.size() == 2) begin
            if (iChannelMask[mRs[3:0]]) begin
                m.st = mRs;
`ifdef NOTE_ON_ZERO_AS_OFF_EN
                if (mRs[7:4] == 4'h9 && mPend[1] == 8'h00)
                    m.st = {4'h8, mRs[3:0]};
`endif
                m.nt = mPend[0];
                m.vl = mPend[1];
                expQ.push_back(m);
            end
            mPend.delete();
        end
    endfunction

    task automatic pushByte(input logic [7:0] b);
        fifo.push_back(b);
        modelByte(b);
    endtask

    // Monitor / FIFO driver
    int   readyMode = 1;
    bit   prevRead = 0;
    bit   prevValid = 0;
    bit   prevXfer = 0;
    bit   prevTimeout = 0;
    logic [7:0] heldSt, heldNt, heldVl;
    int   cycle = 0;
    int   timeoutCount = 0;
    int   lastTimeoutCycle = 0;

    always begin
        msg_t e;
        @(negedge gClock);
        cycle++;
        if (prevRead && fifo.size() > 0) void'(fifo.pop_front());
        if (gReset) begin
            if (prevValid && !prevXfer) begin
                checkVal("hold_valid", oMsgValid, 1);
                checkVal("hold_status", oStatus, heldSt);
                checkVal("hold_note", oNote, heldNt);
                checkVal("hold_vel", oVelocity, heldVl);
            end
            if (oTimeout) begin
                checkVal("timeout_width", prevTimeout, 0);
                timeoutCount++;
                lastTimeoutCycle = cycle;
            end
        end
        prevTimeout = oTimeout;
        iByteValid = (fifo.size() > 0);
        iByte = iByteValid ? fifo[0] : 8'($urandom);
        iMsgReady = (readyMode == 2) ? 1'($urandom_range(1)) : (readyMode == 1);
        #1;
        if (gReset) begin
            if (oByteRead) checkVal("read_gap", prevRead, 0);
            if (oMsgValid) checkVal("read_in_hold", oByteRead, 0);
            if (fifo.size() > 0 && !oMsgValid && !prevRead) checkVal("read_req", oByteRead, 1);
            if (oMsgValid && iMsgReady) begin
                if (expQ.size() == 0) begin
                    checkVal("unexpected_msg", {oStatus, oNote, oVelocity}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkVal("msg_status", oStatus, e.st);
                    checkVal("msg_note", oNote, e.nt);
                    checkVal("msg_vel", oVelocity, e.vl);
                end
            end
        end
        prevRead = oByteRead;
        prevValid = oMsgValid;
        prevXfer = oMsgValid && iMsgReady;
        heldSt = oStatus;
        heldNt = oNote;
        heldVl = oVelocity;
    end

    task automatic waitDrain(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge gClock);
            #3;
            if (fifo.size() == 0 && expQ.size() == 0 && !oMsgValid && !prevRead) break;
        end
        checkVal({tag, "_fifo"}, fifo.size(), 0);
        checkVal({tag, "_pending"}, expQ.size(), 0);
        checkVal({tag, "_valid"}, oMsgValid, 0);
    endtask

    task automatic waitFifoEmpty(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge gClock);
            #3;
            if (fifo.size() == 0 && !prevRead) break;
        end
    endtask

    function automatic logic [7:0] randByte();
        int r;
        r = $urandom_range(99);
        if (r < 55) return 8'($urandom_range(127));
        if (r < 75) return 8'(8'h80 + $urandom_range(31));
        if (r < 83) return 8'(8'hF8 + $urandom_range(7));
        if (r < 87) return 8'(8'hF0 + $urandom_range(7));
        return 8'(8'hA0 + $urandom_range(8'h4F));
    endfunction

    initial begin
        int startCycle;
        int delta;

        repeat (3) @(negedge gClock);
        #3;
        checkVal("rst_status", oStatus, 0);
        checkVal("rst_note", oNote, 0);
        checkVal("rst_vel", oVelocity, 0);
        checkVal("rst_valid", oMsgValid, 0);
        checkVal("rst_read", oByteRead, 0);
        checkVal("rst_timeout", oTimeout, 0);
        @(posedge gClock); #2;
        gReset = 1'b1;

        // Directed: single message, running status, embedded realtime, channel filter
        pushByte(8'h90); pushByte(8'h3C); pushByte(8'h64);
        waitDrain("basic", 200);
        pushByte(8'h3E); pushByte(8'h40);
        waitDrain("running", 200);
        pushByte(8'h90); pushByte(8'h3C); pushByte(8'hF8); pushByte(8'h64);
        waitDrain("realtime", 200);
        iChannelMask = 16'h0001;
        pushByte(8'h91); pushByte(8'h3C); pushByte(8'h64);
        pushByte(8'h90); pushByte(8'h3C); pushByte(8'h64);
        waitDrain("mask", 200);
        iChannelMask = 16'hFFFF;

        // Back-pressure: consumer stalls while the FIFO still holds bytes
        readyMode = 0;
        pushByte(8'h93); pushByte(8'h10); pushByte(8'h20); pushByte(8'h30); pushByte(8'h40);
        repeat (25) @(negedge gClock);
        #3;
        checkVal("stall_valid", oMsgValid, 1);
        checkVal("stall_status", oStatus, 8'h93);
        checkVal("stall_fifo_left", fifo.size(), 2);
        readyMode = 1;
        waitDrain("stall", 200);

        pushByte(8'h99); pushByte(8'h24); pushByte(8'h00);
        waitDrain("vel_zero", 200);

        // Reset mid-message drops running status and the partial message
        pushByte(8'h90); pushByte(8'h3C);
        waitFifoEmpty(100);
        @(posedge gClock); #2;
        gReset = 1'b0;
        @(posedge gClock); #2;
        gReset = 1'b1;
        mRsNote = 0;
        mPend.delete();
        checkVal("midrst_valid", oMsgValid, 0);
        pushByte(8'h3E); pushByte(8'h40);
        pushByte(8'h92); pushByte(8'h11); pushByte(8'h22);
        waitDrain("midrst", 200);

        // Randomised streams
        for (int p = 0; p < 6; p++) begin
            iChannelMask = (p % 2 == 1) ? 16'hFFFF : 16'($urandom);
            readyMode = (p % 3 == 0) ? 1 : 2;
            for (int i = 0; i < 60; i++) pushByte(randByte());
            waitDrain("random", 4000);
        end
        readyMode = 1;
        iChannelMask = 16'hFFFF;
        checkVal("no_spurious_timeout", timeoutCount, 0);

        // Inter-byte timeout aborts the partial message but keeps running status
        pushByte(8'h90); pushByte(8'h3C);
        waitFifoEmpty(100);
        startCycle = cycle;
        for (int i = 0; i < 50100; i++) begin
            @(negedge gClock);
            #3;
            if (timeoutCount > 0) break;
        end
        mPend.delete();
        delta = lastTimeoutCycle - startCycle;
        checkVal("timeout_count", timeoutCount, 1);
        checkVal("timeout_window", (delta >= 50000 && delta <= 50004), 1);
        checkVal("timeout_no_msg", expQ.size(), 0);
        pushByte(8'h40); pushByte(8'h50);
        waitDrain("after_timeout", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/midi_msg_sequencer.md
Name: midi_msg_sequencer

Overview:
- Controller between the UART receive FIFO and the pattern/light logic.
- Pops bytes from the FIFO with a read handshake and assembles Note-On/Note-Off messages, including MIDI running status.
- Filters messages by channel and presents each message to the downstream consumer with valid/ready back-pressure.
- Discards realtime and system bytes and aborts partial messages on an inter-byte timeout.

Parameters:
- pTimeoutCycles, 50000: idle clocks allowed between data bytes of one message (1 ms at 50 MHz).
- pTimerWidth, 16: timeout counter width; must hold pTimeoutCycles.

Ports:
- gClock  input  1  system clock; all state updates on rising edge.
- gReset  input  1  reset, synchronous, active-low.
- iByte  input  8  FIFO head byte; valid only while iByteValid=1.
- iByteValid  input  1  FIFO data present (level).
- oByteRead  output  1  one-cycle pop strobe; iByte is consumed in the cycle it is high.
- iChannelMask  input  16  bit n=1 passes channel n (status low nibble).
- oStatus  output  8  message status byte (8x/9x).
- oNote  output  8  note number, 0-127.
- oVelocity  output  8  velocity, 0-127.
- oMsgValid  output  1  message held on outputs.
- iMsgReady  input  1  consumer accepts; transfer when oMsgValid & iMsgReady.
- oTimeout  output  1  one-cycle pulse when a partial message is aborted.

Behaviour:
- Reset (gReset=0 at a clock edge):
  - All outputs 0; state IDLE.
  - Running-status register 0 and invalid; timer 0.
- Byte consumption:
  - oByteRead=1 when iByteValid=1, state is not HOLD, and oByteRead was 0 in the previous cycle.
  - oByteRead is never high on two consecutive cycles (FIFO flag settles one cycle after a pop). Maximum rate: one byte per 2 clocks.
- Byte classes, applied in every state except HOLD:
  - F8-FF (realtime): consumed, ignored; state, running status and timer unchanged.
  - F0-F7 (system): running status invalidated; go to IDLE.
  - 8x/9x: running status := byte, marked note-type; go to DATA1.
  - Ax-Ex: running status := byte, marked non-note; go to IDLE.
  - 00-7F (data): handled per state, below.
- States:
  - IDLE, data byte with note-type running status: note := byte; go to DATA2.
  - IDLE, data byte with invalid or non-note running status: byte discarded.
  - DATA1, data byte: note := byte; go to DATA2.
  - DATA2, data byte: velocity := byte. If iChannelMask[status[3:0]]=1, load outputs and go to HOLD; otherwise go to IDLE with no output.
  - HOLD: oMsgValid=1; outputs stable; no pops. When iMsgReady=1, go to IDLE next cycle with oMsgValid=0.
- Latency: oMsgValid rises the cycle after the clock edge that pops the final data byte.
- Running status persists across messages. Message N+1 needs only 2 data bytes.
- Timeout:
  - Timer counts clocks in DATA1/DATA2; it clears on every popped non-realtime byte and holds 0 in IDLE/HOLD.
  - When the count reaches pTimeoutCycles: go to IDLE, keep running status, pulse oTimeout for 1 cycle.
  - A pop in the same cycle as expiry takes priority; no timeout occurs.
- Reset in any state, including HOLD or mid-message, discards everything; the popped FIFO byte is not restored.
- iChannelMask is sampled at the DATA2 completion cycle only.

Optional Feature:
- Macro: NOTE_ON_ZERO_AS_OFF_EN.
- Defined: a 9x message with velocity 0 is presented with oStatus = {4'h8, channel}, i.e. as Note-Off. The running-status register stays 9x.
- Undefined: status passed through unchanged.

Decomposition:
- Package midi_pkg holds:
  - the state encoding: IDLE, DATA1, DATA2, HOLD;
  - constants NOTE_OFF_NIB=4'h8, NOTE_ON_NIB=4'h9, SYS_BASE=8'hF0, RT_BASE=8'hF8.
- One sub-module: midi_timeout_timer, a parameterised clear/enable counter with an expiry pulse.

Test Plan:
- Pop 90,3C,64, iMsgReady=1, mask=FFFF -> one oMsgValid with 90/3C/64, then oMsgValid=0; oByteRead never high two consecutive cycles.
- 90,3C,64 then 3E,40 -> second message 90/3E/40 via running status.
- 90,3C,F8,64 -> message 90/3C/64; F8 is popped and ignored.
- 91,3C,64 with mask=0001 -> no oMsgValid; next 90,3C,64 is output.
- 90,3C then idle 50000 clocks -> oTimeout pulse, state IDLE; next 40,50 -> message 90/40/50.
- iMsgReady=0 for 20 cycles while FIFO holds bytes -> outputs stable and no oByteRead; 99,24,00 with the macro defined -> oStatus=89.
